router_pkt_tx: RTL and testbench

//  Packet source for the 1x3 router input port. Buffers one payload from a

---
 rtl/router_pkt_tx_if.sv | 30 +++
 rtl/router_pkt_tx.sv | 196 +++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Purpose: payload-stream and router-side bus of router_pkt_tx.
//   src_data/src_valid/src_ready : valid/ready payload byte stream into the buffer
//   busy                         : router back-pressure, holds the current beat
//   data_out/pkt_valid           : registered byte stream to router data_in
//   header/parity/payload_len/addr : descriptors of the packet in flight
//   tx_done                      : one-cycle pulse when the parity beat is accepted
// modport master = packet source (router_pkt_tx); slave = payload feeder / router side.
interface router_pkt_tx_if;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic [7:0] header;
    logic [7:0] parity;
    logic [5:0] payload_len;
    logic [1:0] addr;
    logic       tx_done;

    modport master (
        input  src_data, src_valid, busy,
        output src_ready, data_out, pkt_valid, header, parity, payload_len, addr, tx_done
    );

    modport slave (
        output src_data, src_valid, busy,
        input  src_ready, data_out, pkt_valid, header, parity, payload_len, addr, tx_done
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Purpose: packet source for the 1x3 router input port. Buffers one payload
// from a valid/ready byte stream, then sends header, payload and parity to the
// router, holding the current beat while the router reports busy.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : packet request, sampled only in IDLE
//   addr_in      : destination port (0..2; BAD_ADDR rejected)
//   len_in       : payload length 1..63 (0 rejected)
//   inj_err      : only with PARITY_ERR_INJ_EN; sends inverted parity beat
//   req_err      : one-cycle pulse after a rejected start
//   tx_idle      : high while IDLE
//   bus          : router_pkt_tx_if.master (payload stream + router outputs)
// Optional feature macro: PARITY_ERR_INJ_EN (parity error injection).
module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [1:0]  BAD_ADDR   = 2'd3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         addr_in,
    input  logic [5:0]         len_in,
`ifdef PARITY_ERR_INJ_EN
    input  logic               inj_err,
`endif
    output logic               req_err,
    output logic               tx_idle,
    router_pkt_tx_if.master    bus
);

    localparam int unsigned DEPTH = 64;
    localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_GAP     = 3'd5
    } state_e;

    state_e           state_q;
    logic [5:0]       len_q;
    logic [1:0]       addr_q;
    logic [7:0]       header_q;
    logic [7:0]       parity_q;
    logic [5:0]       wptr_q;
    logic [5:0]       rptr_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             src_ready_q;
    logic [7:0]       data_out_q;
    logic             pkt_valid_q;
    logic             tx_done_q;
    logic             req_err_q;
    logic             tx_idle_q;
    logic [7:0]       pay_buf_q [DEPTH];
`ifdef PARITY_ERR_INJ_EN
    logic             inj_q;
`endif

    logic             start_ok_c;
    logic             last_wr_c;
    logic             last_rd_c;
    logic [7:0]       par_beat_c;

    // Request qualification and pointer end-of-packet detection
    always_comb begin
        start_ok_c = (len_in != 6'd0) && (addr_in != BAD_ADDR);
        last_wr_c  = (wptr_q == (len_q - 6'd1));
        last_rd_c  = (rptr_q == (len_q - 6'd1));
`ifdef PARITY_ERR_INJ_EN
        par_beat_c = parity_q ^ {8{inj_q}};
`else
        par_beat_c = parity_q;
`endif
    end

    // Payload buffer; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clock) begin
        if (state_q == S_LOAD && bus.src_valid) begin
            pay_buf_q[wptr_q] <= bus.src_data;
        end
    end

    // Packet sequencer with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= 6'd0;
            addr_q      <= 2'd0;
            header_q    <= 8'd0;
            parity_q    <= 8'd0;
            wptr_q      <= 6'd0;
            rptr_q      <= 6'd0;
            gap_cnt_q   <= GAP_W'(0);
            src_ready_q <= 1'b0;
            data_out_q  <= 8'd0;
            pkt_valid_q <= 1'b0;
            tx_done_q   <= 1'b0;
            req_err_q   <= 1'b0;
            tx_idle_q   <= 1'b1;
`ifdef PARITY_ERR_INJ_EN
            inj_q       <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            req_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (start_ok_c) begin
                            len_q       <= len_in;
                            addr_q      <= addr_in;
                            header_q    <= {len_in, addr_in};
                            parity_q    <= {len_in, addr_in};
                            wptr_q      <= 6'd0;
                            src_ready_q <= 1'b1;
                            tx_idle_q   <= 1'b0;
`ifdef PARITY_ERR_INJ_EN
                            inj_q       <= inj_err;
`endif
                            state_q     <= S_LOAD;
                        end else begin
                            req_err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.src_valid) begin
                        parity_q <= parity_q ^ bus.src_data;
                        wptr_q   <= wptr_q + 6'd1;
                        // Header goes out the cycle right after the last payload beat
                        if (last_wr_c) begin
                            src_ready_q <= 1'b0;
                            data_out_q  <= header_q;
                            pkt_valid_q <= 1'b1;
                            state_q     <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (!bus.busy) begin
                        rptr_q     <= 6'd0;
                        data_out_q <= pay_buf_q[0];
                        state_q    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!bus.busy) begin
                        if (last_rd_c) begin
                            data_out_q  <= par_beat_c;
                            pkt_valid_q <= 1'b0;
                            state_q     <= S_PARITY;
                        end else begin
                            rptr_q     <= rptr_q + 6'd1;
                            data_out_q <= pay_buf_q[rptr_q + 6'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (!bus.busy) begin
                        data_out_q <= 8'd0;
                        tx_done_q  <= 1'b1;
                        gap_cnt_q  <= GAP_W'(0);
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Fixed idle spacing; router busy is not consulted here
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        tx_idle_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.src_ready   = src_ready_q;
    assign bus.data_out    = data_out_q;
    assign bus.pkt_valid   = pkt_valid_q;
    assign bus.header      = header_q;
    assign bus.parity      = parity_q;
    assign bus.payload_len = len_q;
    assign bus.addr        = addr_q;
    assign bus.tx_done     = tx_done_q;
    assign req_err         = req_err_q;
    assign tx_idle         = tx_idle_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed packets plus randomized packets, each
// checked against an expected beat list built from the packet contents.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] addr_in;
    logic [5:0] len_in;
    logic       req_err;
    logic       tx_idle;
`ifdef PARITY_ERR_INJ_EN
    logic       inj_err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] pay [64];

    router_pkt_tx_if bus();

    router_pkt_tx dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .addr_in (addr_in),
        .len_in  (len_in),
`ifdef PARITY_ERR_INJ_EN
        .inj_err (inj_err),
`endif
        .req_err (req_err),
        .tx_idle (tx_idle),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (!tx_idle && cyc < 50) begin
            tick();
            cyc++;
        end
        check_eq("idle_wait", 32'(tx_idle), 32'd1);
    endtask

    // busy_mode: 0 never busy, 1 random busy, 2 busy for 3 cycles on payload byte 1
    task automatic run_packet(input logic [1:0] a, input logic [5:0] n,
                              input int busy_mode, input logic inj);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] beats [$];
        logic       inj_eff;
        int         k;
        int         got;
        int         cyc;
        int         hold;

        wait_idle();
`ifdef PARITY_ERR_INJ_EN
        inj_eff = inj;
`else
        inj_eff = 1'b0;
`endif
        hdr = {n, a};
        par = hdr;
        for (int i = 0; i < int'(n); i++) par = par ^ pay[i];
        beats = {};
        beats.push_back(hdr);
        for (int i = 0; i < int'(n); i++) beats.push_back(pay[i]);
        beats.push_back(par ^ {8{inj_eff}});

        start   = 1'b1;
        addr_in = a;
        len_in  = n;
`ifdef PARITY_ERR_INJ_EN
        inj_err = inj;
`endif
        tick();
        start = 1'b0;
        check_eq("load_ready", 32'(bus.src_ready), 32'd1);
        check_eq("load_not_idle", 32'(tx_idle), 32'd0);

        got = 0;
        cyc = 0;
        while (got < int'(n) && cyc < 1000) begin
            check_eq("load_src_ready", 32'(bus.src_ready), 32'd1);
            check_eq("load_pkt_valid", 32'(bus.pkt_valid), 32'd0);
            check_eq("load_req_err", 32'(req_err), 32'd0);
            bus.src_valid = ($urandom_range(0, 3) != 0);
            bus.src_data  = pay[got];
            bus.busy      = 1'($urandom);
            start         = 1'($urandom);
            addr_in       = 2'($urandom);
            len_in        = 6'($urandom);
            tick();
            if (bus.src_valid) got++;
            cyc++;
        end
        bus.src_valid = 1'b0;
        start = 1'b0;
        check_eq("load_timeout", 32'(got), 32'(n));

        check_eq("hdr_src_ready", 32'(bus.src_ready), 32'd0);
        check_eq("hdr_port", 32'(bus.header), 32'(hdr));
        check_eq("len_port", 32'(bus.payload_len), 32'(n));
        check_eq("addr_port", 32'(bus.addr), 32'(a));
        check_eq("parity_port", 32'(bus.parity), 32'(par));

        k    = 0;
        cyc  = 0;
        hold = 0;
        while (k < int'(n) + 2 && cyc < 2000) begin
            check_eq("tx_data", 32'(bus.data_out), 32'(beats[k]));
            check_eq("tx_pkt_valid", 32'(bus.pkt_valid), 32'(k <= int'(n)));
            check_eq("tx_done_early", 32'(bus.tx_done), 32'd0);
            check_eq("tx_src_ready", 32'(bus.src_ready), 32'd0);
            check_eq("tx_req_err", 32'(req_err), 32'd0);
            check_eq("tx_hdr_hold", 32'(bus.header), 32'(hdr));
            check_eq("tx_par_hold", 32'(bus.parity), 32'(par));
            case (busy_mode)
                1: bus.busy = ($urandom_range(0, 2) == 0);
                2: begin
                    bus.busy = (k == 2 && hold < 3);
                    if (bus.busy) hold++;
                end
                default: bus.busy = 1'b0;
            endcase
            bus.src_valid = 1'($urandom);
            start   = 1'($urandom);
            addr_in = 2'($urandom);
            len_in  = 6'($urandom);
            tick();
            if (!bus.busy) k++;
            cyc++;
        end
        start = 1'b0;
        bus.src_valid = 1'b0;
        check_eq("tx_timeout", 32'(k), 32'(int'(n) + 2));

        bus.busy = 1'($urandom);
        check_eq("gap1_done", 32'(bus.tx_done), 32'd1);
        check_eq("gap1_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("gap1_data", 32'(bus.data_out), 32'd0);
        check_eq("gap1_idle", 32'(tx_idle), 32'd0);
        tick();
        bus.busy = 1'($urandom);
        check_eq("gap2_done", 32'(bus.tx_done), 32'd0);
        check_eq("gap2_data", 32'(bus.data_out), 32'd0);
        check_eq("gap2_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("gap2_idle", 32'(tx_idle), 32'd0);
        tick();
        bus.busy = 1'b0;
        check_eq("back_idle", 32'(tx_idle), 32'd1);
        check_eq("back_done", 32'(bus.tx_done), 32'd0);
    endtask

    task automatic bad_start(input logic [1:0] a, input logic [5:0] n);
        wait_idle();
        start   = 1'b1;
        addr_in = a;
        len_in  = n;
        tick();
        start = 1'b0;
        check_eq("rej_req_err", 32'(req_err), 32'd1);
        check_eq("rej_src_ready", 32'(bus.src_ready), 32'd0);
        check_eq("rej_idle", 32'(tx_idle), 32'd1);
        check_eq("rej_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        tick();
        check_eq("rej_pulse_end", 32'(req_err), 32'd0);
        check_eq("rej_src_ready2", 32'(bus.src_ready), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
        check_eq({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
        check_eq({tag, "_tx_idle"}, 32'(tx_idle), 32'd1);
        check_eq({tag, "_src_ready"}, 32'(bus.src_ready), 32'd0);
        check_eq({tag, "_tx_done"}, 32'(bus.tx_done), 32'd0);
        check_eq({tag, "_req_err"}, 32'(req_err), 32'd0);
        check_eq({tag, "_header"}, 32'(bus.header), 32'd0);
        check_eq({tag, "_parity"}, 32'(bus.parity), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        addr_in       = 2'd0;
        len_in        = 6'd0;
        bus.src_valid = 1'b0;
        bus.src_data  = 8'd0;
        bus.busy      = 1'b0;
`ifdef PARITY_ERR_INJ_EN
        inj_err       = 1'b0;
`endif
        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();
        check_reset_state("post_rst");

        // Basic three-byte packet
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        run_packet(2'd1, 6'd3, 0, 1'b0);
        // Same packet with busy holding the second payload byte
        run_packet(2'd1, 6'd3, 2, 1'b0);
        // Rejected requests
        bad_start(2'd3, 6'd5);
        bad_start(2'd0, 6'd0);
        // Maximum length, byte i = i
        for (int i = 0; i < 64; i++) pay[i] = 8'(i);
        run_packet(2'd2, 6'd63, 0, 1'b0);
        // Single-byte packet
        pay[0] = 8'h5A;
        run_packet(2'd0, 6'd1, 1, 1'b0);

        // Reset while payload is on the wire
        wait_idle();
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
        start = 1'b1; addr_in = 2'd2; len_in = 6'd10;
        tick();
        start = 1'b0;
        bus.src_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.src_data = pay[i];
            tick();
        end
        bus.src_valid = 1'b0;
        bus.busy = 1'b0;
        tick();
        tick();
        tick();
        check_eq("pre_rst_valid", 32'(bus.pkt_valid), 32'd1);
        check_eq("pre_rst_data", 32'(bus.data_out), 32'(pay[2]));
        reset = 1'b1;
        tick();
        check_reset_state("mid_rst");
        reset = 1'b0;
        tick();
        check_eq("after_rst_done", 32'(bus.tx_done), 32'd0);
        check_eq("after_rst_valid", 32'(bus.pkt_valid), 32'd0);
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        run_packet(2'd1, 6'd3, 0, 1'b0);

`ifdef PARITY_ERR_INJ_EN
        // Inverted parity beat, true parity on the parity port
        run_packet(2'd1, 6'd3, 0, 1'b1);
`endif

        // Randomized traffic with interleaved rejected requests
        for (int p = 0; p < 25; p++) begin
            logic [5:0] n;
            n = 6'($urandom_range(1, 63));
            for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
            run_packet(2'($urandom_range(0, 2)), n, 1, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) bad_start(2'd3, 6'($urandom));
                else bad_start(2'($urandom), 6'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
